// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI mode-0 (CPOL=0, CPHA=0) target. It oversamples sclk/mosi/cs_n with
//   the system clock, shifts received data in MSB first, and drives miso MSB
//   first. Several words may be exchanged back-to-back inside one cs_n frame.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sclk, mosi, cs_n  SPI bus from the master (asynchronous to clk)
//   miso, miso_oe     SPI data back to the master and its drive enable
//   slave_send_data   next word to transmit, sampled only when tx_load pulses
//   tx_load           1-clk pulse: slave_send_data was sampled this cycle
//   slave_rx_data     last complete word received
//   rx_done           1-clk pulse: slave_rx_data was updated this cycle
//   busy              frame active
//   abort             1-clk pulse: frame ended in the middle of a word
module spi_slave_core #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] slave_send_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] slave_rx_data,
    output logic              rx_done,
    output logic              busy,
    output logic              abort
);

    localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;

    // ------------------------------------------------------------------
    // Input synchronizers. All three pins use the same depth so that the
    // mosi value seen on a detected sclk rise is the one the master set up
    // for that rise. Reset values are the idle bus levels so no edge is
    // seen when reset is released on an idle bus.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync   <= '0;
            mosi_sync_q <= '0;
            cs_sync     <= '1;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b1;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_d      <= sclk_sync[SYNC_STAGES-1];
            cs_d        <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign cs_fall   = ~cs_s   &  cs_d;
    assign cs_rise   =  cs_s   & ~cs_d;

    // ------------------------------------------------------------------
    // Frame FSM with all outputs registered. Pulses default low each clk.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            miso          <= 1'b0;
            miso_oe       <= 1'b0;
            tx_load       <= 1'b0;
            slave_rx_data <= '0;
            rx_done       <= 1'b0;
            busy          <= 1'b0;
            abort         <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            rx_done <= 1'b0;
            abort   <= 1'b0;

            if (cs_rise) begin
                // End of frame takes priority over any sclk edge in the
                // same cycle; a partial word is dropped and flagged.
                state   <= IDLE;
                busy    <= 1'b0;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
                bit_cnt <= '0;
                if (bit_cnt != '0)
                    abort <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= ACTIVE;
                            busy    <= 1'b1;
                            tx_sr   <= slave_send_data;
                            miso    <= slave_send_data[DATA_W-1];
                            tx_load <= 1'b1;
                            bit_cnt <= '0;
                            miso_oe <= 1'b1;
                        end
                    end

                    ACTIVE: begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
                            if (bit_cnt == LAST_BIT) begin
                                slave_rx_data <= {rx_sr[DATA_W-2:0], mosi_s};
                                rx_done       <= 1'b1;
                                bit_cnt       <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (sclk_fall) begin
                            if (bit_cnt != '0) begin
                                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                                miso  <= tx_sr[DATA_W-2];
                            end else begin
                                // Word boundary: fetch the next word so its
                                // MSB is on miso before the next rise.
                                tx_sr   <= slave_send_data;
                                miso    <= slave_send_data[DATA_W-1];
                                tx_load <= 1'b1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
